// File: rtl/i2c_slave_if.sv
// I2C responder bus bundle: SCL/SDA wires plus the local payload handshake.
// SDA is resolved here as an open-drain line with a pull-up and one driver per side.
interface i2c_slave_if;
  logic        scl;
  wire         sda;
  logic        sda_oe;       // responder pulls SDA low
  logic        m_sda_oe;     // bus master pulls SDA low
  logic [15:0] tx_data;
  logic        tx_two_bytes;
  logic [15:0] rx_data;
  logic        rx_two_bytes;
  logic        rx_valid;
  logic        busy;

  assign sda = sda_oe ? 1'b0 : 1'bz;
  assign sda = m_sda_oe ? 1'b0 : 1'bz;
  pullup (sda);

  modport slave (
    input  scl,
    inout  sda,
    output sda_oe,
    input  tx_data,
    input  tx_two_bytes,
    output rx_data,
    output rx_two_bytes,
    output rx_valid,
    output busy
  );

  modport master (
    output scl,
    inout  sda,
    output m_sda_oe,
    input  sda_oe,
    output tx_data,
    output tx_two_bytes,
    input  rx_data,
    input  rx_two_bytes,
    input  rx_valid,
    input  busy
  );
endinterface

// File: rtl/i2c_slave.sv
// I2C responder: 7-bit address, up to two write bytes, up to two read bytes then 0xFF.
// Bus lines are oversampled by clk; SDA only ever changes after a synchronized SCL fall.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h2A
) (
  input  logic       clk,
  input  logic       rst_n,
  i2c_slave_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StRxByte, StRxAck, StTxByte, StTxAck, StWaitStop
  } state_e;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], bus.scl};
      sda_sync_q <= {sda_sync_q[0], bus.sda};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  // Byte to transmit for a given index; past the payload the line is left released.
  function automatic logic [7:0] tx_pick(input logic [15:0] d, input logic two,
                                         input logic [1:0] idx);
    if (idx == 2'd0) return two ? d[15:8] : d[7:0];
    if (idx == 2'd1 && two) return d[7:0];
    return 8'hFF;
  endfunction

  state_e      state_q;
  logic [2:0]  bit_cnt_q;
  logic        full_q;
  logic [7:0]  shift_q;
  logic        rw_q;
  logic [1:0]  byte_cnt_q;
  logic [7:0]  byte0_q, byte1_q;
  logic        wr_act_q;
  logic [15:0] tx_buf_q;
  logic        tx_two_q;
  logic [1:0]  tx_sent_q;
  logic [7:0]  tx_sh_q;
  logic        mack_q;
  logic        sda_oe_q;
  logic        busy_q;
  logic [15:0] rx_data_q;
  logic        rx_two_q;
  logic        rx_valid_q;
  logic [7:0]  tx_first, tx_next;

  assign tx_first = tx_pick(bus.tx_data, bus.tx_two_bytes, 2'd0);
  assign tx_next  = tx_pick(tx_buf_q, tx_two_q, tx_sent_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 3'd7;
      full_q     <= 1'b0;
      shift_q    <= 8'h00;
      rw_q       <= 1'b0;
      byte_cnt_q <= 2'd0;
      byte0_q    <= 8'h00;
      byte1_q    <= 8'h00;
      wr_act_q   <= 1'b0;
      tx_buf_q   <= 16'h0000;
      tx_two_q   <= 1'b0;
      tx_sent_q  <= 2'd0;
      tx_sh_q    <= 8'hFF;
      mack_q     <= 1'b1;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= 16'h0000;
      rx_two_q   <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (start_det || stop_det) begin
        // A write is delivered on either STOP or repeated START.
        if (wr_act_q && byte_cnt_q != 2'd0) begin
          rx_data_q  <= (byte_cnt_q == 2'd2) ? {byte0_q, byte1_q} : {8'h00, byte0_q};
          rx_two_q   <= (byte_cnt_q == 2'd2);
          rx_valid_q <= 1'b1;
        end
        wr_act_q   <= 1'b0;
        byte_cnt_q <= 2'd0;
        sda_oe_q   <= 1'b0;
        busy_q     <= 1'b0;
        full_q     <= 1'b0;
        bit_cnt_q  <= 3'd7;
        state_q    <= start_det ? StAddr : StIdle;
      end else begin
        unique case (state_q)
          StAddr, StRxByte: begin
            if (scl_rise && !full_q) begin
              shift_q <= {shift_q[6:0], sda_s};
              if (bit_cnt_q == 3'd0) full_q <= 1'b1;
              else bit_cnt_q <= bit_cnt_q - 3'd1;
            end else if (scl_fall && full_q) begin
              full_q    <= 1'b0;
              bit_cnt_q <= 3'd7;
              if (state_q == StAddr) begin
                if (shift_q[7:1] == SLAVE_ADDR) begin
                  rw_q     <= shift_q[0];
                  sda_oe_q <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= StAddrAck;
                end else begin
                  state_q <= StWaitStop;
                end
              end else if (byte_cnt_q == 2'd2) begin
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
                state_q  <= StWaitStop;
              end else begin
                if (byte_cnt_q == 2'd0) byte0_q <= shift_q;
                else byte1_q <= shift_q;
                byte_cnt_q <= byte_cnt_q + 2'd1;
                sda_oe_q   <= 1'b1;
                state_q    <= StRxAck;
              end
            end
          end
          StAddrAck: begin
            if (scl_fall) begin
              if (rw_q) begin
                tx_buf_q  <= bus.tx_data;
                tx_two_q  <= bus.tx_two_bytes;
                tx_sent_q <= 2'd1;
                sda_oe_q  <= ~tx_first[7];
                tx_sh_q   <= {tx_first[6:0], 1'b1};
                state_q   <= StTxByte;
              end else begin
                wr_act_q   <= 1'b1;
                byte_cnt_q <= 2'd0;
                sda_oe_q   <= 1'b0;
                state_q    <= StRxByte;
              end
            end
          end
          StRxAck: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              state_q  <= StRxByte;
            end
          end
          StTxByte: begin
            if (scl_rise && !full_q) begin
              if (bit_cnt_q == 3'd0) full_q <= 1'b1;
              else bit_cnt_q <= bit_cnt_q - 3'd1;
            end else if (scl_fall) begin
              if (full_q) begin
                full_q    <= 1'b0;
                bit_cnt_q <= 3'd7;
                sda_oe_q  <= 1'b0;
                state_q   <= StTxAck;
              end else begin
                sda_oe_q <= ~tx_sh_q[7];
                tx_sh_q  <= {tx_sh_q[6:0], 1'b1};
              end
            end
          end
          StTxAck: begin
            if (scl_rise) begin
              mack_q <= sda_s;
            end else if (scl_fall) begin
              if (!mack_q) begin
                sda_oe_q  <= ~tx_next[7];
                tx_sh_q   <= {tx_next[6:0], 1'b1};
                tx_sent_q <= (tx_sent_q == 2'd2) ? 2'd2 : tx_sent_q + 2'd1;
                state_q   <= StTxByte;
              end else begin
                busy_q  <= 1'b0;
                state_q <= StWaitStop;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.sda_oe       = sda_oe_q;
  assign bus.busy         = busy_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_two_bytes = rx_two_q;
  assign bus.rx_valid     = rx_valid_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a table of whole bus transactions plus hand-written
// sequences for repeated START and reset in the middle of a read.
module tb_i2c_slave;
  localparam int QCLK = 8;  // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_slave_if bus ();

  i2c_slave #(.SLAVE_ADDR(7'h2A)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  int rv_total = 0, oe_total = 0, viol = 0;
  logic prev_oe = 1'b0, prev_scl = 1'b1;
  always @(posedge clk) begin
    prev_oe  <= bus.sda_oe;
    prev_scl <= bus.scl;
    if (rst_n && bus.scl && prev_scl && bus.sda_oe != prev_oe) viol <= viol + 1;
    if (rst_n && bus.rx_valid) rv_total <= rv_total + 1;
    if (bus.sda_oe) oe_total <= oe_total + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic q();
    repeat (QCLK) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    bus.m_sda_oe = 1'b0; q();
    bus.scl = 1'b1; q();
    bus.m_sda_oe = 1'b1; q();
    bus.scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    bus.m_sda_oe = 1'b1; q();
    bus.scl = 1'b1; q();
    bus.m_sda_oe = 1'b0; q();
  endtask

  task automatic clock_bit(input logic b, output logic s);
    bus.m_sda_oe = ~b; q();
    bus.scl = 1'b1; q();
    s = bus.sda; q();
    bus.scl = 1'b0; q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int k = 7; k >= 0; k--) clock_bit(d[k], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic s;
    for (int k = 7; k >= 0; k--) begin
      clock_bit(1'b1, s);
      d[k] = s;
    end
    clock_bit(~ack, s);
  endtask

  typedef struct {
    logic        rd;
    int          n;
    logic [7:0]  ab;
    logic [23:0] wd;
    logic [15:0] txd;
    logic        txt;
    logic        exp_aack;
    logic [2:0]  exp_acks;
    logic [23:0] exp_rd;
    logic [15:0] exp_rx;
    logic        exp_two;
    int          exp_pulses;
  } vec_t;

  vec_t vecs [10];
  vec_t t;
  logic a;
  logic [7:0] b;
  logic [2:0] ga;
  logic [23:0] got;
  int rv0, oe0;

  initial begin
    //           rd  n  addr   wdata        txd       txt aack acks    exp_rd       rx       two p
    vecs[0] = '{1'b0, 1, 8'h54, 24'hA50000, 16'h0000, 1'b0, 1'b1, 3'b001, 24'h000000, 16'h00A5, 1'b0, 1};
    vecs[1] = '{1'b0, 2, 8'h54, 24'h123400, 16'h0000, 1'b0, 1'b1, 3'b011, 24'h000000, 16'h1234, 1'b1, 1};
    vecs[2] = '{1'b1, 2, 8'h55, 24'h000000, 16'hBEEF, 1'b1, 1'b1, 3'b000, 24'hBEEF00, 16'h1234, 1'b1, 0};
    vecs[3] = '{1'b0, 1, 8'h20, 24'h770000, 16'h0000, 1'b0, 1'b0, 3'b000, 24'h000000, 16'h1234, 1'b1, 0};
    vecs[4] = '{1'b0, 3, 8'h54, 24'h010203, 16'h0000, 1'b0, 1'b1, 3'b011, 24'h000000, 16'h0102, 1'b1, 1};
    vecs[5] = '{1'b1, 2, 8'h55, 24'h000000, 16'h00C3, 1'b0, 1'b1, 3'b000, 24'hC3FF00, 16'h0102, 1'b1, 0};
    vecs[6] = '{1'b1, 3, 8'h55, 24'h000000, 16'h5A3C, 1'b1, 1'b1, 3'b000, 24'h5A3CFF, 16'h0102, 1'b1, 0};
    vecs[7] = '{1'b0, 0, 8'h54, 24'h000000, 16'h0000, 1'b0, 1'b1, 3'b000, 24'h000000, 16'h0102, 1'b1, 0};
    vecs[8] = '{1'b0, 1, 8'h54, 24'h3C0000, 16'h0000, 1'b0, 1'b1, 3'b001, 24'h000000, 16'h003C, 1'b0, 1};
    vecs[9] = '{1'b1, 1, 8'h21, 24'h000000, 16'h0000, 1'b0, 1'b0, 3'b000, 24'hFF0000, 16'h003C, 1'b0, 0};

    bus.scl = 1'b1;
    bus.m_sda_oe = 1'b0;
    bus.tx_data = 16'h0000;
    bus.tx_two_bytes = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_rx_data", {16'h0, bus.rx_data}, 32'h0);
    chk("rst_rx_two", {31'h0, bus.rx_two_bytes}, 32'h0);
    chk("rst_rx_valid", {31'h0, bus.rx_valid}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_sda_oe", {31'h0, bus.sda_oe}, 32'h0);
    rst_n = 1'b1;
    q();

    for (int v = 0; v < 10; v++) begin
      t = vecs[v];
      bus.tx_data = t.txd;
      bus.tx_two_bytes = t.txt;
      rv0 = rv_total;
      oe0 = oe_total;
      i2c_start();
      write_byte(t.ab, a);
      chk($sformatf("v%0d_addr_ack", v), {31'h0, a}, {31'h0, t.exp_aack});
      chk($sformatf("v%0d_busy_mid", v), {31'h0, bus.busy}, {31'h0, t.exp_aack});
      if (t.rd) begin
        got = 24'h0;
        for (int i = 0; i < t.n; i++) begin
          read_byte(b, i != t.n - 1);
          got[23 - 8 * i -: 8] = b;
        end
        chk($sformatf("v%0d_read_bytes", v), {8'h0, got}, {8'h0, t.exp_rd});
        chk($sformatf("v%0d_release_after_nack", v), {31'h0, bus.sda_oe}, 32'h0);
      end else begin
        ga = 3'b000;
        for (int i = 0; i < t.n; i++) begin
          write_byte(t.wd[23 - 8 * i -: 8], a);
          ga[i] = a;
        end
        chk($sformatf("v%0d_data_acks", v), {29'h0, ga}, {29'h0, t.exp_acks});
      end
      i2c_stop();
      q();
      chk($sformatf("v%0d_rx_pulses", v), rv_total - rv0, t.exp_pulses);
      chk($sformatf("v%0d_rx_data", v), {16'h0, bus.rx_data}, {16'h0, t.exp_rx});
      chk($sformatf("v%0d_rx_two", v), {31'h0, bus.rx_two_bytes}, {31'h0, t.exp_two});
      chk($sformatf("v%0d_busy_idle", v), {31'h0, bus.busy}, 32'h0);
      if (!t.exp_aack) chk($sformatf("v%0d_no_drive", v), oe_total - oe0, 0);
    end

    // Write ended by a repeated START, followed by a 1-byte read.
    bus.tx_data = 16'h1234;
    bus.tx_two_bytes = 1'b0;
    rv0 = rv_total;
    i2c_start();
    write_byte(8'h54, a);
    write_byte(8'hAB, a);
    write_byte(8'hCD, a);
    chk("rs_second_ack", {31'h0, a}, 32'h1);
    i2c_start();
    chk("rs_pulse", rv_total - rv0, 1);
    chk("rs_rx_data", {16'h0, bus.rx_data}, 32'h0000ABCD);
    chk("rs_rx_two", {31'h0, bus.rx_two_bytes}, 32'h1);
    chk("rs_busy_after_start", {31'h0, bus.busy}, 32'h0);
    write_byte(8'h55, a);
    chk("rs_read_addr_ack", {31'h0, a}, 32'h1);
    read_byte(b, 1'b0);
    chk("rs_read_byte", {24'h0, b}, 32'h34);
    i2c_stop();
    q();
    chk("rs_no_extra_pulse", rv_total - rv0, 1);

    // Reset while the responder holds a 0 data bit on the bus.
    bus.tx_data = 16'h0012;
    bus.tx_two_bytes = 1'b0;
    i2c_start();
    write_byte(8'h55, a);
    bus.m_sda_oe = 1'b0; q();
    bus.scl = 1'b1; q();
    chk("mr_drives_zero", {31'h0, bus.sda}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_sda_released", {31'h0, bus.sda}, 32'h1);
    chk("mr_sda_oe", {31'h0, bus.sda_oe}, 32'h0);
    chk("mr_rx_data", {16'h0, bus.rx_data}, 32'h0);
    chk("mr_busy", {31'h0, bus.busy}, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    bus.scl = 1'b0; q();
    rst_n = 1'b1; q();
    oe0 = oe_total;
    write_byte(8'h54, a);
    chk("mr_ignore_until_start", {31'h0, a}, 32'h0);
    chk("mr_ignore_no_drive", oe_total - oe0, 0);
    i2c_stop();
    rv0 = rv_total;
    i2c_start();
    write_byte(8'h54, a);
    chk("mr_addr_ack", {31'h0, a}, 32'h1);
    write_byte(8'h5A, a);
    chk("mr_data_ack", {31'h0, a}, 32'h1);
    i2c_stop();
    q();
    chk("mr_rx_data_after", {16'h0, bus.rx_data}, 32'h005A);
    chk("mr_pulse_after", rv_total - rv0, 1);

    chk("oe_stable_scl_high", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h2A, the 7-bit address this responder answers to.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port scl, input, 1 bit: bus clock, sampled only; the responder never drives it and never stretches the clock.
REQ-005 SHALL have port sda, inout, 1 bit: open-drain data line, driven 1'b0 when sda_oe=1, otherwise 1'bz.
REQ-006 SHALL have port tx_data, input, 16 bits: read payload, latched on the address ACK when rw=1.
REQ-007 SHALL have port tx_two_bytes, input, 1 bit: latched with tx_data; 1 sends [15:8] then [7:0], 0 sends [7:0] only.
REQ-008 SHALL have port rx_data, output, 16 bits: received write payload; holds its value until the next valid write.
REQ-009 SHALL have port rx_two_bytes, output, 1 bit: 1 when the last write carried 2 bytes, 0 when it carried 1.
REQ-010 SHALL have port rx_valid, output, 1 bit: one-clk pulse marking a completed write.
REQ-011 SHALL have port busy, output, 1 bit: high from an address match until the next STOP or START.

Function
REQ-012 SHALL pass scl and sda through 2-flop synchronizers, then through edge detection; clk SHALL be at least 8x the SCL frequency.
REQ-013 SHALL detect START as synchronized sda falling while scl high, and STOP as sda rising while scl high.
REQ-014 SHALL sample sda on each synchronized scl rising edge, and SHALL change sda_oe only on the synchronized scl falling edge.
REQ-015 SHALL implement these FSM states: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
REQ-016 START from any state, including a repeated START mid-transfer, SHALL enter ADDR with bit count 7 and release sda.
REQ-017 STOP from any state SHALL enter IDLE and release sda.
REQ-018 ADDR SHALL shift 8 bits MSB first: 7 address bits, then the rw bit.
- Address == SLAVE_ADDR: enter ADDR_ACK and drive sda low for one SCL period.
- Otherwise: enter WAIT_STOP and never drive sda.
REQ-019 After ADDR_ACK:
- rw=0: enter RX_BYTE.
- rw=1: latch tx_data and tx_two_bytes, enter TX_BYTE, and drive the first bit on the same scl falling edge that ends the ACK.
REQ-020 RX_BYTE SHALL shift 8 bits MSB first into a byte register.
- Byte count 0 or 1: ACK in RX_ACK, then return to RX_BYTE.
- Byte count 2 (a third byte): NACK it (sda released) and enter WAIT_STOP.
REQ-021 At STOP following a write of 1 or 2 ACKed bytes:
- 2 bytes: rx_data = {byte0, byte1}.
- 1 byte: rx_data = {8'h00, byte0}.
- Set rx_two_bytes accordingly and pulse rx_valid for exactly one clk.
- A write ended by a repeated START SHALL behave identically.
- 0 data bytes: no pulse.
REQ-022 TX_BYTE SHALL drive bits MSB first, with sda_oe = ~bit.
- Order: tx_data[15:8] then [7:0] when tx_two_bytes=1, else [7:0] only.
- Once all payload bytes are sent, further bytes SHALL be 8'hFF (sda released).
REQ-023 TX_ACK SHALL release sda and sample the master's ACK.
- ACK (sda low): the next TX_BYTE.
- NACK (sda high): WAIT_STOP.
REQ-024 busy SHALL be 1 in ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE and TX_ACK; 0 otherwise.
REQ-025 The responder SHALL never drive sda while scl is high, except to hold a bit it set up on the preceding falling edge.

Reset
REQ-026 While rst_n=0:
- state = IDLE, sda_oe = 0 (sda released);
- rx_data = 16'h0000, rx_two_bytes = 0, rx_valid = 0, busy = 0;
- synchronizer flops = 1.
REQ-027 Reset asserted mid-transfer SHALL release sda immediately, without waiting for clk.
REQ-028 After rst_n deasserts, the responder SHALL ignore bus activity until the first START.

Verification
REQ-029 Write, 1 byte: START, 0x54 (addr 2A, W), 0xA5, STOP -> two ACKs; rx_data = 16'h00A5, rx_two_bytes = 0, one rx_valid pulse.
REQ-030 Write, 2 bytes: START, 0x54, 0x12, 0x34, STOP -> three ACKs; rx_data = 16'h1234, rx_two_bytes = 1.
REQ-031 Read, 2 bytes: tx_data = 16'hBEEF, tx_two_bytes = 1; START, 0x55, master ACK, then NACK, STOP -> bus carries 0xBE, 0xEF; sda released after the NACK.
REQ-032 Address mismatch: START, 0x20 -> sda never driven low, busy = 0, no rx_valid pulse.
REQ-033 Third write byte: START, 0x54, 0x01, 0x02, 0x03 -> third byte NACKed; at STOP rx_data = 16'h0102.
REQ-034 Reset mid-read: rst_n = 0 while driving a 0 bit -> sda = z at once; rx_data = 0; after release, a normal 1-byte write succeeds.
